// File: rtl/cursor_input.sv
// cursor_input: debounced push-button front end and 3x3 grid cursor.
// Three active-low keys (confirm, restart, readkey) and four udlr switches
// are synchronized; each key is debounced and turned into a one-cycle press
// strobe. A readkey press moves the cursor one cell in the single direction
// selected on udlr. Optional feature macro: CURSOR_WRAP_EN (moves off an edge
// wrap within the row/column instead of being ignored).
module cursor_input #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       confirm_n,
  input  logic       restart_n,
  input  logic       readkey_n,
  input  logic [3:0] udlr,
  input  logic       locked,
  output logic [8:0] cursorGrid,
  output logic [3:0] cursor_idx,
  output logic       confirm,
  output logic       restart
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [8:0] GRID_TOP = 9'b100000000;

  // key index 0 = confirm, 1 = restart, 2 = readkey
  logic [2:0] key_raw;
  logic [2:0] key_sync1_reg, key_sync2_reg;
  logic [3:0] udlr_sync1_reg, udlr_sync2_reg;
  logic [1:0] settle_reg;
  logic       settled;
  logic [2:0] key_strobe;

  assign key_raw = {readkey_n, restart_n, confirm_n};
  assign settled = (settle_reg == 2'd2);

  // Two-flop synchronizers; keys idle released, switches idle at 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_sync1_reg  <= 3'b111;
      key_sync2_reg  <= 3'b111;
      udlr_sync1_reg <= 4'b0000;
      udlr_sync2_reg <= 4'b0000;
    end else begin
      key_sync1_reg  <= key_raw;
      key_sync2_reg  <= key_sync1_reg;
      udlr_sync1_reg <= udlr;
      udlr_sync2_reg <= udlr_sync1_reg;
    end
  end

  // Counts the two edges needed to flush the reset value out of the
  // synchronizers, so a key held through reset is not mistaken for released.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      settle_reg <= 2'd0;
    end else if (!settled) begin
      settle_reg <= settle_reg + 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_key
      logic [CNT_W-1:0] cnt_reg;
      logic             level_reg;
      logic             armed_reg;
      logic             strobe_reg;

      // Debounce: the level follows the synchronized input only after it has
      // differed for DEBOUNCE_CYCLES consecutive cycles. A press strobes only
      // when the key has been seen released since reset (armed).
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt_reg    <= '0;
          level_reg  <= 1'b1;
          armed_reg  <= 1'b0;
          strobe_reg <= 1'b0;
        end else begin
          strobe_reg <= 1'b0;
          if (key_sync2_reg[gi] != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
              cnt_reg    <= '0;
              level_reg  <= key_sync2_reg[gi];
              strobe_reg <= armed_reg & ~key_sync2_reg[gi];
              if (key_sync2_reg[gi]) armed_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
            if (settled && key_sync2_reg[gi]) armed_reg <= 1'b1;
          end
        end
      end

      assign key_strobe[gi] = strobe_reg;
    end
  endgenerate

  logic [1:0] row_reg, col_reg;
  logic [1:0] row_next, col_next;
  logic       move_en;

  assign move_en = key_strobe[2] & ~locked;

  // Next cell for the single direction selected on udlr; anything that is
  // not exactly one-hot leaves the cursor where it is.
  always_comb begin
    row_next = row_reg;
    col_next = col_reg;
    case (udlr_sync2_reg)
      4'b1000: begin
        if (row_reg != 2'd0) row_next = row_reg - 2'd1;
`ifdef CURSOR_WRAP_EN
        else row_next = 2'd2;
`endif
      end
      4'b0100: begin
        if (row_reg != 2'd2) row_next = row_reg + 2'd1;
`ifdef CURSOR_WRAP_EN
        else row_next = 2'd0;
`endif
      end
      4'b0010: begin
        if (col_reg != 2'd0) col_next = col_reg - 2'd1;
`ifdef CURSOR_WRAP_EN
        else col_next = 2'd2;
`endif
      end
      4'b0001: begin
        if (col_reg != 2'd2) col_next = col_reg + 2'd1;
`ifdef CURSOR_WRAP_EN
        else col_next = 2'd0;
`endif
      end
      default: begin
        row_next = row_reg;
        col_next = col_reg;
      end
    endcase
  end

  // Cursor position; restart has priority over a simultaneous move.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_reg <= 2'd0;
      col_reg <= 2'd0;
    end else if (key_strobe[1]) begin
      row_reg <= 2'd0;
      col_reg <= 2'd0;
    end else if (move_en) begin
      row_reg <= row_next;
      col_reg <= col_next;
    end
  end

  assign cursor_idx = {1'b0, row_reg, 1'b0} + {2'b00, row_reg} + {2'b00, col_reg};
  assign cursorGrid = GRID_TOP >> cursor_idx;
  assign confirm    = key_strobe[0] & ~locked;
  assign restart    = key_strobe[1];

endmodule

// File: tb/tb_cursor_input.sv
// Self-checking bench for cursor_input (DEBOUNCE_CYCLES = 4).
module tb_cursor_input;

  localparam int DB = 4;
`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       confirm_n, restart_n, readkey_n;
  logic [3:0] udlr;
  logic       locked;
  logic [8:0] cursorGrid;
  logic [3:0] cursor_idx;
  logic       confirm, restart;

  cursor_input #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock(clock), .reset(reset),
    .confirm_n(confirm_n), .restart_n(restart_n), .readkey_n(readkey_n),
    .udlr(udlr), .locked(locked),
    .cursorGrid(cursorGrid), .cursor_idx(cursor_idx),
    .confirm(confirm), .restart(restart)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  int confirm_cnt = 0, restart_cnt = 0;
  int confirm_cyc = 0, confirm_idx = 0;
  int check_cnt = 0, pass_cnt = 0;
  int m_idx = 0;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (confirm === 1'b1) begin
      confirm_cnt++;
      confirm_cyc = cyc;
      confirm_idx = int'(cursor_idx);
    end
    if (restart === 1'b1) restart_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic press(input bit c, input bit r, input bit k, input int hold);
    if (c) confirm_n = 1'b0;
    if (r) restart_n = 1'b0;
    if (k) readkey_n = 1'b0;
    tick(hold);
    confirm_n = 1'b1;
    restart_n = 1'b1;
    readkey_n = 1'b1;
    tick(10);
  endtask

  // Reference cursor model on a 3x3 grid in row/column terms.
  function automatic int ref_move(input int idx, input logic [3:0] u);
    int nr = idx / 3;
    int nc = idx % 3;
    if (u == 4'b1000)      nr = nr - 1;
    else if (u == 4'b0100) nr = nr + 1;
    else if (u == 4'b0010) nc = nc - 1;
    else if (u == 4'b0001) nc = nc + 1;
    else return idx;
    if (nr < 0 || nr > 2 || nc < 0 || nc > 2) begin
      if (!WRAP) return idx;
      nr = (nr + 3) % 3;
      nc = (nc + 3) % 3;
    end
    return nr * 3 + nc;
  endfunction

  function automatic logic [8:0] ref_grid(input int idx);
    logic [8:0] g;
    g = '0;
    g[8 - idx] = 1'b1;
    return g;
  endfunction

  task automatic check_cursor(input string tag);
    check({tag, "_idx"}, 32'(cursor_idx), 32'(m_idx));
    check({tag, "_grid"}, 32'(cursorGrid), 32'(ref_grid(m_idx)));
  endtask

  task automatic move(input logic [3:0] u);
    udlr = u;
    tick(3);
    press(0, 0, 1, 12);
    if (!locked) m_idx = ref_move(m_idx, u);
  endtask

  int lat, c0, r0, stop_cyc;
  logic [3:0] u;
  bit lk, rs;

  initial begin
    reset = 1'b0; confirm_n = 1'b1; restart_n = 1'b1; readkey_n = 1'b1;
    udlr = 4'b0000; locked = 1'b0;
    tick(3);
    check("rst_idx", 32'(cursor_idx), 32'd0);
    check("rst_grid", 32'(cursorGrid), 32'h100);
    check("rst_confirm", 32'(confirm), 32'd0);
    check("rst_restart", 32'(restart), 32'd0);

    // Idle after reset release.
    reset = 1'b1;
    tick(10);
    check_cursor("idle");
    check("idle_strobes", 32'(confirm_cnt + restart_cnt), 32'd0);

    // Clean right move from cell 0, with latency measurement.
    udlr = 4'b0001;
    tick(3);
    readkey_n = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (cursor_idx != 4'd0) begin
        lat = i;
        break;
      end
    end
    check("move_latency_ok", 32'((lat - 1 >= DB) && (lat - 1 <= DB + 4)), 32'd1);
    m_idx = 1;
    check_cursor("right");
    readkey_n = 1'b1;
    tick(10);

    // Restart back to 0, then left off the edge.
    r0 = restart_cnt;
    press(0, 1, 0, 12);
    m_idx = 0;
    check("restart_once", 32'(restart_cnt - r0), 32'd1);
    check_cursor("restart");
    move(4'b0010);
    check("left_edge_idx", 32'(cursor_idx), WRAP ? 32'd2 : 32'd0);
    check_cursor("left_edge");

    // Bouncing confirm, then a steady press.
    c0 = confirm_cnt;
    for (int i = 0; i < 5; i++) begin
      confirm_n = 1'b0; tick(2);
      confirm_n = 1'b1; tick(2);
    end
    stop_cyc = cyc;
    check("bounce_no_pulse", 32'(confirm_cnt - c0), 32'd0);
    confirm_n = 1'b0;
    tick(10);
    check("bounce_one_pulse", 32'(confirm_cnt - c0), 32'd1);
    check("pulse_after_bounce", 32'(confirm_cyc > stop_cyc), 32'd1);
    check("confirm_latency_ok",
          32'((confirm_cyc - stop_cyc >= DB) && (confirm_cyc - stop_cyc <= DB + 4)), 32'd1);
    tick(20);
    check("held_one_pulse", 32'(confirm_cnt - c0), 32'd1);
    confirm_n = 1'b1;
    tick(10);
    check("release_no_pulse", 32'(confirm_cnt - c0), 32'd1);

    // Reach cell 4, then lock.
    press(0, 1, 0, 12);
    m_idx = 0;
    move(4'b0100);
    move(4'b0001);
    check("at_center", 32'(cursor_idx), 32'd4);
    locked = 1'b1;
    udlr = 4'b1000;
    tick(3);
    c0 = confirm_cnt;
    press(1, 0, 1, 12);
    check_cursor("locked_move");
    check("locked_confirm", 32'(confirm_cnt - c0), 32'd0);
    r0 = restart_cnt;
    press(0, 1, 0, 12);
    m_idx = 0;
    check("locked_restart", 32'(restart_cnt - r0), 32'd1);
    check_cursor("locked_restart");
    locked = 1'b0;

    // Confirm and readkey together: confirm sees the pre-move cursor.
    udlr = 4'b0001;
    tick(3);
    c0 = confirm_cnt;
    press(1, 0, 1, 12);
    m_idx = ref_move(m_idx, 4'b0001);
    check("both_confirm", 32'(confirm_cnt - c0), 32'd1);
    check("both_confirm_idx", 32'(confirm_idx), 32'd0);
    check_cursor("both_move");

    // Not one-hot: no move. Then restart and readkey together.
    move(4'b0100);
    move(4'b1001);
    check_cursor("not_onehot");
    udlr = 4'b0001;
    tick(3);
    press(0, 1, 1, 12);
    m_idx = 0;
    check_cursor("restart_wins");

    // Randomized moves, occasional lock and concurrent restart.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 7) < 5) u = 4'b0001 << $urandom_range(0, 3);
      else u = 4'($urandom);
      lk = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 7) == 0);
      udlr = u;
      locked = lk;
      tick(3);
      r0 = restart_cnt;
      press(0, rs, 1, 12);
      if (rs) m_idx = 0;
      else if (!lk) m_idx = ref_move(m_idx, u);
      check_cursor($sformatf("rand%0d", it));
      check($sformatf("rand%0d_restart", it), 32'(restart_cnt - r0), 32'(rs));
      check($sformatf("rand%0d_onehot", it), 32'($countones(cursorGrid)), 32'd1);
      locked = 1'b0;
    end

    // Reset mid-debounce with readkey still held afterwards.
    udlr = 4'b0001;
    tick(3);
    readkey_n = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("midreset_idx", 32'(cursor_idx), 32'd0);
    reset = 1'b1;
    m_idx = 0;
    tick(20);
    check_cursor("held_after_reset");
    readkey_n = 1'b1;
    tick(10);
    check_cursor("released_after_reset");
    press(0, 0, 1, 12);
    m_idx = ref_move(m_idx, 4'b0001);
    check_cursor("repress_after_reset");

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/cursor_input.md
CURSOR_INPUT -- requirements
Module: cursor_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, sets the consecutive stable cycles needed to accept a key level (10 ms at 50 MHz).
REQ-002 Port clock  input  1  single system clock; all state on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port confirm_n  input  1  raw push-button, active-low (pressed = 0).
REQ-005 Port restart_n  input  1  raw push-button, active-low.
REQ-006 Port readkey_n  input  1  raw push-button, active-low; commits a cursor move.
REQ-007 Port udlr  input  4  raw slide switches; bit3 = up, bit2 = down, bit1 = left, bit0 = right.
REQ-008 Port locked  input  1  game-over flag (win or loss); high blocks moves and confirms.
REQ-009 Port cursorGrid  output  9  one-hot cursor; bit8 = cell 0 (top-left), bit0 = cell 8 (bottom-right).
REQ-010 Port cursor_idx  output  4  cursor cell index = row*3 + col, range 0..8.
REQ-011 Port confirm  output  1  one-cycle press strobe.
REQ-012 Port restart  output  1  one-cycle press strobe.

Function
REQ-013 Each key and each udlr bit SHALL pass through a two-flop synchronizer before any other use.
REQ-014 Each key SHALL have its own debounce counter; the debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-015 Any bounce back to the current debounced level SHALL clear that key's counter to 0.
REQ-016 A 1->0 transition of a debounced level SHALL produce exactly one high cycle on that key's strobe; a release SHALL produce none.
REQ-017 A held key SHALL produce one strobe only, however long it is held.
REQ-018 Strobe latency from a clean raw press SHALL be at least DEBOUNCE_CYCLES and at most DEBOUNCE_CYCLES+4 cycles.
REQ-019 On a readkey press, the move SHALL be decoded from synchronized udlr; if udlr is not exactly one-hot, no move SHALL occur.
REQ-020 Up/down SHALL change the row by -1/+1; left/right SHALL change the column by -1/+1; the move SHALL appear on cursor_idx and cursorGrid the cycle after the readkey strobe.
REQ-021 The edge behaviour of a move is set by REQ-033.
REQ-022 cursorGrid SHALL always equal 9'b100000000 >> cursor_idx and SHALL be exactly one-hot at all times out of reset.
REQ-023 While locked is high, readkey moves SHALL be ignored and the confirm strobe SHALL be forced to 0.
REQ-024 The restart strobe SHALL be unaffected by locked.
REQ-025 A restart strobe SHALL set cursor_idx to 0 on the next cycle.
REQ-026 If restart and readkey strobe in the same cycle, restart SHALL win.
REQ-027 If confirm and readkey strobe in the same cycle, both SHALL be honoured; confirm corresponds to the pre-move cursor, which updates on the next cycle.

Reset
REQ-028 While reset is low, cursor_idx = 0 and cursorGrid = 9'b100000000, asynchronously.
REQ-029 While reset is low, confirm = 0 and restart = 0.
REQ-030 Reset SHALL clear all debounce counters and set all synchronizer and debounced key levels to released (1); udlr synchronizers SHALL be cleared to 0.
REQ-031 Reset asserted mid-debounce SHALL discard the pending press; a key still held after reset release SHALL produce no strobe until it is released and pressed again.
REQ-032 Reset release SHALL take effect on the first rising clock edge after reset goes high.

Configuration
REQ-033 Macro CURSOR_WRAP_EN: defined, a move off a grid edge SHALL wrap within the same row or column (left from col 0 -> col 2; up from row 0 -> row 2); undefined, a move off an edge SHALL leave the cursor unchanged.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-034 Reset low, then release, no keys pressed -> cursorGrid=9'b100000000, cursor_idx=0, both strobes 0.
REQ-035 From idx 0, udlr=4'b0001, clean readkey press -> one strobe within 4..8 cycles; next cycle cursor_idx=1, cursorGrid=9'b010000000.
REQ-036 From idx 0, udlr=4'b0010, readkey press -> cursor_idx=2 with CURSOR_WRAP_EN defined; stays 0 without it.
REQ-037 confirm_n toggling every 2 cycles for 20 cycles, then held low for 10 cycles -> exactly one confirm pulse, occurring after the toggling stops.
REQ-038 locked=1, idx=4, udlr=4'b1000, readkey and confirm pressed -> cursor stays 4 and confirm stays 0; restart press -> restart pulses once and cursor_idx becomes 0.
REQ-039 udlr=4'b1001 with readkey press -> no move; restart and readkey strobing in the same cycle -> cursor_idx=0.
